// File: rtl/ga_pkg.sv
// Shared types and constants for the GA core: fitness word, tournament
// scheduler states and the 16-bit LFSR polynomial/seed.
package ga_pkg;
  localparam int FIT_W = 27;

  typedef logic signed [FIT_W-1:0] fitness_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRAW = 3'd1,
    RD_A = 3'd2,
    RD_B = 3'd3,
    CMP  = 3'd4,
    EMIT = 3'd5
  } tsched_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, bit i of the mask is polynomial term i+1
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and step enable; shared by the
// tournament scheduler and the mutation unit.
module ga_lfsr16
  import ga_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed_in,
  input  logic        en,
  output logic [15:0] state
);

  // An all-zero state would lock up the register, so a zero seed maps to SEED.
  always_ff @(posedge clk) begin
    if (rst)
      state <= SEED;
    else if (load)
      state <= (seed_in == 16'h0000) ? SEED : seed_in;
    else if (en)
      state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/tournament_scheduler.sv
// Binary tournament selection: draws two distinct indices, reads both
// fitness values through one RAM port and emits the lower-fitness index.
module tournament_scheduler #(
  parameter int          POP_SIZE  = 16,
  parameter int          IDX_W     = $clog2(POP_SIZE),
  parameter int          FIT_W     = ga_pkg::FIT_W,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] LFSR_SEED = ga_pkg::LFSR_SEED_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_parents,
  input  logic                    seed_we,
  input  logic [15:0]             seed_in,
  output logic [IDX_W-1:0]        fit_addr,
  input  logic signed [FIT_W-1:0] fit_data,
  output logic                    winner_valid,
  input  logic                    winner_ready,
  output logic [IDX_W-1:0]        winner_idx,
  output logic                    busy,
  output logic                    done
);
  import ga_pkg::*;

  tsched_state_e            state;
  logic [15:0]              lfsr;
  logic [CNT_W-1:0]         count, n_lat, count_nx;
  logic [IDX_W-1:0]         idx_a, idx_b;
  logic [IDX_W-1:0]         draw_a, draw_b_raw, draw_b;
  logic signed [FIT_W-1:0]  fit_a;
  logic                     hs;

  assign draw_a     = lfsr[IDX_W-1:0];
  assign draw_b_raw = lfsr[15 -: IDX_W];
  // Equal draws bump idx_b by one (mod POP_SIZE) so the pair is always distinct.
  assign draw_b     = (draw_b_raw == draw_a) ? draw_a + IDX_W'(1) : draw_b_raw;

  assign hs       = winner_valid && winner_ready;
  assign count_nx = count + CNT_W'(1);
  assign busy     = (state != IDLE);

  ga_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    ((state == IDLE) && seed_we),
    .seed_in (seed_in),
    .en      (state == DRAW),
    .state   (lfsr)
  );

  // fit_addr is registered one state ahead so the RAM's one-cycle read
  // latency lands fit_a in RD_B and fit_b in CMP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      n_lat        <= '0;
      idx_a        <= '0;
      idx_b        <= '0;
      fit_a        <= '0;
      fit_addr     <= '0;
      winner_idx   <= '0;
      winner_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (n_parents == '0) begin
              done <= 1'b1;
            end else begin
              n_lat <= n_parents;
              count <= '0;
              state <= DRAW;
            end
          end
        end
        DRAW: begin
          idx_a    <= draw_a;
          idx_b    <= draw_b;
          fit_addr <= draw_a;
          state    <= RD_A;
        end
        RD_A: begin
          fit_addr <= idx_b;
          state    <= RD_B;
        end
        RD_B: begin
          fit_a <= fit_data;
          state <= CMP;
        end
        CMP: begin
          // lower fitness wins; ties go to idx_b
          winner_idx   <= (fit_a < fit_data) ? idx_a : idx_b;
          winner_valid <= 1'b1;
          state        <= EMIT;
        end
        EMIT: begin
          if (hs) begin
            winner_valid <= 1'b0;
            count        <= count_nx;
            if (count_nx == n_lat) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= DRAW;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tournament_scheduler.sv
// Scoreboard bench for tournament_scheduler: a reference LFSR plus fitness
// RAM model predicts each winner when a run is started.
module tb_tournament_scheduler;
  import ga_pkg::*;

  localparam int POP   = 16;
  localparam int IW    = 4;
  localparam int CW    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   n_parents;
  logic            seed_we;
  logic [15:0]     seed_in;
  logic [IW-1:0]   fit_addr;
  fitness_t        fit_data;
  logic            winner_valid;
  logic            winner_ready;
  logic [IW-1:0]   winner_idx;
  logic            busy;
  logic            done;

  fitness_t        ram [POP];
  logic [15:0]     m_lfsr = 16'hACE1;
  logic [IW-1:0]   exp_q [$];
  int              hs_q  [$];
  int              cyc = 0;
  int              n_chk = 0;
  int              n_err = 0;
  int              done_cnt = 0;

  tournament_scheduler #(.POP_SIZE(POP), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_parents    (n_parents),
    .seed_we      (seed_we),
    .seed_in      (seed_in),
    .fit_addr     (fit_addr),
    .fit_data     (fit_data),
    .winner_valid (winner_valid),
    .winner_ready (winner_ready),
    .winner_idx   (winner_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) fit_data <= ram[fit_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Drive start for one edge and predict the run; exp_ovr >= 0 forces the
  // expected winner of a single-tournament run to a hand-derived constant.
  task automatic start_run(input int n, input bit swe, input logic [15:0] sd, input int exp_ovr);
    logic [IW-1:0] a, b;
    start = 1'b1; n_parents = CW'(n); seed_we = swe; seed_in = sd;
    if (swe) m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int i = 0; i < n; i++) begin
      a = m_lfsr[3:0];
      b = m_lfsr[15:12];
      if (b == a) b = a + 4'd1;
      if (exp_ovr >= 0) exp_q.push_back(IW'(exp_ovr));
      else              exp_q.push_back((ram[a] < ram[b]) ? a : b);
      m_lfsr = lfsr_nx(m_lfsr);
    end
    @(posedge clk); #1;
    start = 1'b0; seed_we = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk(tag, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (winner_valid && winner_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) chk("extra_winner", 32'(exp_q.size()), 32'd1);
        else                   chk("winner", 32'(winner_idx), 32'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_vld", 32'(winner_valid), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, k, i0, fa0;
    rst = 1'b1; start = 1'b0; n_parents = '0; seed_we = 1'b0; seed_in = '0;
    winner_ready = 1'b1;
    for (int i = 0; i < POP; i++) ram[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(winner_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(fit_addr), 32'd0);
    chk("rst_idx", 32'(winner_idx), 32'd0);
    @(posedge clk); #1;

    // descending fitness: the higher index of each pair should win
    for (int i = 0; i < POP; i++) ram[i] = fitness_t'(-(i * 1000));
    hs_q.delete();
    d0 = done_cnt;
    start_run(4, 1'b0, 16'h0, -1);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (winner_valid) k = i;
    end
    chk("first_vld_lat", 32'(k), 32'd5);
    wait_done("t1_done");
    chk("t1_nwin", 32'(hs_q.size()), 32'd4);
    for (int i = 1; i < hs_q.size(); i++)
      chk("t1_spacing", 32'(hs_q[i] - hs_q[i-1]), 32'd5);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // all ties: idx_b every time
    for (int i = 0; i < POP; i++) ram[i] = fitness_t'(42);
    start_run(3, 1'b1, 16'h1234, -1);
    wait_done("t2_done");

    // seed F00F draws 15/15, idx_b wraps to 0
    for (int i = 0; i < POP; i++) ram[i] = '0;
    ram[15] = fitness_t'(-5); ram[0] = fitness_t'(7);
    start_run(1, 1'b1, 16'hF00F, 15);
    wait_done("t3a_done");
    ram[15] = fitness_t'(7); ram[0] = fitness_t'(-5);
    start_run(1, 1'b1, 16'hF00F, 0);
    wait_done("t3b_done");

    // seed 3005: idx_a=5, idx_b=3; signed compare
    ram[5] = fitness_t'(-1); ram[3] = fitness_t'(1);
    start_run(1, 1'b1, 16'h3005, 5);
    wait_done("t4a_done");
    ram[5] = '1; ram[3] = '0;
    start_run(1, 1'b1, 16'h3005, 5);
    wait_done("t4b_done");

    // backpressure, with a start pulse during EMIT that must be ignored
    winner_ready = 1'b0;
    start_run(1, 1'b1, 16'h3005, 5);
    k = 0;
    for (int i = 0; i < 20 && k == 0; i++) begin
      @(negedge clk);
      if (winner_valid) k = 1;
    end
    chk("bp_vld_seen", 32'(k), 32'd1);
    i0 = winner_idx; fa0 = fit_addr;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        @(posedge clk); #1 start = 1'b1; n_parents = 8'd5;
        @(posedge clk); #1 start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("bp_vld", 32'(winner_valid), 32'd1);
      chk("bp_idx", 32'(winner_idx), 32'(i0));
      chk("bp_addr", 32'(fit_addr), 32'(fa0));
    end
    @(posedge clk); #1 winner_ready = 1'b1;
    wait_done("bp_done");
    repeat (10) @(negedge clk);
    chk("bp_start_ign", 32'(busy), 32'd0);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    // continue from the un-reseeded LFSR: any stray advance shows up here
    for (int i = 0; i < POP; i++) ram[i] = fitness_t'((i * 37) % 11 - 5);
    start_run(2, 1'b0, 16'h0, -1);
    wait_done("t5_done");

    // n_parents == 0
    start_run(0, 1'b0, 16'h0, -1);
    @(negedge clk);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("n0_pulse", 32'(done), 32'd0);
    @(posedge clk); #1;

    // zero seed falls back to ACE1
    start_run(2, 1'b1, 16'h0000, -1);
    wait_done("t7_done");

    // reset while in RD_B
    d0 = done_cnt;
    start_run(2, 1'b0, 16'h0, -1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    m_lfsr = 16'hACE1;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_vld", 32'(winner_valid), 32'd0);
    chk("rstmid_addr", 32'(fit_addr), 32'd0);
    chk("rstmid_idx", 32'(winner_idx), 32'd0);
    repeat (10) @(negedge clk);
    chk("rstmid_nodone", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;
    // post-reset run must restart from the default seed
    start_run(1, 1'b0, 16'h0, -1);
    wait_done("t8_done");
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
